// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline constants: bubble encodings and control-word layout.
// Stages build BUBBLE_CTRL from these named fields.
package pipe_stage_reg_pkg;

  localparam logic [2:0] LOAD_NONE  = 3'b111;
  localparam logic [1:0] STORE_NONE = 2'b11;

  localparam int CTRL_W_EX   = 24;
  localparam int LOAD_LSB    = 0;
  localparam int STORE_LSB   = 3;
  localparam int ALU_OP_LSB  = 5;
  localparam int WB_EN_BIT   = 9;
  localparam int BRANCH_BIT  = 10;
  localparam int JUMP_BIT    = 11;
  localparam int RD_LSB      = 12;

  localparam logic [CTRL_W_EX-1:0] BUBBLE_EX =
    (CTRL_W_EX'(LOAD_NONE) << LOAD_LSB) |
    (CTRL_W_EX'(STORE_NONE) << STORE_LSB);

  localparam logic [15:0] STALL_MAX = 16'hFFFF;

endpackage

// File: rtl/pipe_slot.sv
// One valid+ctrl+data register; load, drop, flush.
// Ports: load/drop/flush controls, ld_* in, valid/ctrl/data out.
module pipe_slot #(
  parameter int CTRL_W = 24,
  parameter int DATA_W = 96,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
  parameter bit CLEAR_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              drop,
  input  logic              flush,
  input  logic [CTRL_W-1:0] ld_ctrl,
  input  logic [DATA_W-1:0] ld_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      ctrl_q <= '0;
      data_q <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      if (CLEAR_DATA) data_q <= '0;
    end else if (load) begin
      valid  <= 1'b1;
      ctrl_q <= ld_ctrl;
      data_q <= ld_data;
    end else if (drop) begin
      valid <= 1'b0;
    end
  end

  // invalid slot never exposes stale write-enables
  assign ctrl = valid ? ctrl_q : BUBBLE_CTRL;
  assign data = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register, optional 2-entry skid.
// Ports: flush, in_* / out_* valid-ready beats, occupancy, stall_cnt.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 24,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = {CTRL_W{1'b0}},
  parameter bit SKID = 1'b1,
  parameter bit CLEAR_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [15:0]       stall_cnt
);

  logic              m_v;
  logic              m_load;
  logic              m_drop;
  logic [CTRL_W-1:0] m_ld_ctrl;
  logic [DATA_W-1:0] m_ld_data;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = m_v & out_ready;
  assign out_valid = m_v;

  pipe_slot #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W),
    .BUBBLE_CTRL(BUBBLE_CTRL),
    .CLEAR_DATA(CLEAR_DATA)
  ) u_main (
    .clk(clk), .rst_n(rst_n),
    .load(m_load), .drop(m_drop), .flush(flush),
    .ld_ctrl(m_ld_ctrl), .ld_data(m_ld_data),
    .valid(m_v), .ctrl(out_ctrl), .data(out_data)
  );

  if (SKID) begin : g_skid
    logic              s_v;
    logic              s_load;
    logic              s_move;
    logic [CTRL_W-1:0] s_ctrl;
    logic [DATA_W-1:0] s_data;

    // s_v is a flop, so in_ready has no path from out_ready
    assign in_ready = ~s_v;
    assign s_move   = out_fire & s_v;
    assign s_load   = in_fire & m_v & ~out_fire;

    always_comb begin
      m_load    = 1'b0;
      m_ld_ctrl = in_ctrl;
      m_ld_data = in_data;
      if (s_move) begin
        m_load    = 1'b1;
        m_ld_ctrl = s_ctrl;
        m_ld_data = s_data;
      end else if (in_fire & (~m_v | out_fire)) begin
        m_load = 1'b1;
      end
    end
    assign m_drop = out_fire;

    pipe_slot #(
      .CTRL_W(CTRL_W), .DATA_W(DATA_W),
      .BUBBLE_CTRL(BUBBLE_CTRL),
      .CLEAR_DATA(CLEAR_DATA)
    ) u_skid (
      .clk(clk), .rst_n(rst_n),
      .load(s_load), .drop(s_move), .flush(flush),
      .ld_ctrl(in_ctrl), .ld_data(in_data),
      .valid(s_v), .ctrl(s_ctrl), .data(s_data)
    );

    assign occupancy = {1'b0, m_v} + {1'b0, s_v};
  end else begin : g_single
    assign in_ready  = ~m_v | out_ready;
    assign m_load    = in_fire;
    assign m_drop    = out_fire;
    assign m_ld_ctrl = in_ctrl;
    assign m_ld_data = in_data;
    assign occupancy = {1'b0, m_v};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (m_v & ~out_ready & (stall_cnt != STALL_MAX)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: SKID=1 (CLEAR_DATA=1) and SKID=0 instances.
// Driver pushes expected beats; negedge monitors pop and compare.
module tb_pipe_stage_reg;
  import pipe_stage_reg_pkg::*;

  localparam logic [23:0] BUB = 24'h00001F;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_fl, a_iv, a_ir, a_ov, a_or;
  logic [23:0] a_ic, a_oc;
  logic [31:0] a_id, a_od;
  logic [1:0]  a_occ;
  logic [15:0] a_st;

  logic        b_fl, b_iv, b_ir, b_ov, b_or;
  logic [23:0] b_ic, b_oc;
  logic [31:0] b_id, b_od;
  logic [1:0]  b_occ;
  logic [15:0] b_st;

  pipe_stage_reg #(
    .DATA_W(32), .CTRL_W(24), .BUBBLE_CTRL(BUBBLE_EX),
    .SKID(1'b1), .CLEAR_DATA(1'b1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(a_fl),
    .in_valid(a_iv), .in_ready(a_ir),
    .in_ctrl(a_ic), .in_data(a_id),
    .out_valid(a_ov), .out_ready(a_or),
    .out_ctrl(a_oc), .out_data(a_od),
    .occupancy(a_occ), .stall_cnt(a_st)
  );

  pipe_stage_reg #(
    .DATA_W(32), .CTRL_W(24), .BUBBLE_CTRL(BUBBLE_EX),
    .SKID(1'b0), .CLEAR_DATA(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_fl),
    .in_valid(b_iv), .in_ready(b_ir),
    .in_ctrl(b_ic), .in_data(b_id),
    .out_valid(b_ov), .out_ready(b_or),
    .out_ctrl(b_oc), .out_data(b_od),
    .occupancy(b_occ), .stall_cnt(b_st)
  );

  int tests = 0;
  int fails = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  function automatic logic [23:0] cf(input logic [31:0] d);
    return d[23:0] ^ 24'h5A5A5A;
  endfunction

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", n, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put_a(input logic [31:0] d);
    a_iv = 1'b1;
    a_id = d;
    a_ic = cf(d);
  endtask

  always @(negedge clk) begin
    if (rst_n && a_ov && a_or) begin
      if (qa.size() == 0) begin
        chk("a_unexpected", a_od, 32'hDEADBEEF);
      end else begin
        logic [31:0] e;
        e = qa.pop_front();
        chk("a_data", a_od, e);
        chk("a_ctrl", 32'(a_oc), 32'(cf(e)));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_ov && b_or) begin
      if (qb.size() == 0) begin
        chk("b_unexpected", b_od, 32'hDEADBEEF);
      end else begin
        logic [31:0] e;
        e = qb.pop_front();
        chk("b_data", b_od, e);
        chk("b_ctrl", 32'(b_oc), 32'(cf(e)));
      end
    end
  end

  bit pat [12] = '{1, 0, 1, 1, 0, 0, 1, 0, 1, 1, 1, 1};

  initial begin
    bit          bocc;
    int          bstall;
    logic [31:0] k;
    logic        er;

    rst_n = 1'b0;
    a_fl = 0; a_iv = 0; a_or = 0; a_ic = '0; a_id = '0;
    b_fl = 0; b_iv = 0; b_or = 0; b_ic = '0; b_id = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov", 32'(a_ov), 0);
    chk("rst_ctrl", 32'(a_oc), 32'(BUB));
    chk("rst_data", a_od, 0);
    chk("rst_occ", 32'(a_occ), 0);
    chk("rst_ir", 32'(a_ir), 1);
    chk("rst_b_ir", 32'(b_ir), 1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // streaming
    a_or = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      put_a(32'(i));
      qa.push_back(32'(i));
      chk("st_ir", 32'(a_ir), 1);
      cyc();
      chk("st_head", a_od, 32'(i));
      chk("st_occ", 32'(a_occ), 1);
    end
    a_iv = 1'b0;
    cyc();
    cyc();
    chk("st_stall", 32'(a_st), 0);
    chk("st_ov", 32'(a_ov), 0);

    // backpressure
    a_or = 1'b0;
    put_a(32'hA);
    qa.push_back(32'hA);
    cyc();
    chk("bp_ir1", 32'(a_ir), 1);
    put_a(32'hB);
    qa.push_back(32'hB);
    cyc();
    chk("bp_ir2", 32'(a_ir), 0);
    chk("bp_occ2", 32'(a_occ), 2);
    put_a(32'hC);
    cyc();
    chk("bp_ir3", 32'(a_ir), 0);
    chk("bp_hold", a_od, 32'hA);
    cyc();
    chk("bp_stall", 32'(a_st), 3);
    a_or = 1'b1;
    cyc();
    chk("bp_ir_up", 32'(a_ir), 1);
    qa.push_back(32'hC);
    cyc();
    a_iv = 1'b0;
    cyc();
    cyc();
    chk("bp_stall_hold", 32'(a_st), 3);
    chk("bp_occ0", 32'(a_occ), 0);

    // flush priority
    a_or = 1'b0;
    put_a(32'hA2);
    qa.push_back(32'hA2);
    cyc();
    put_a(32'hB2);
    qa.push_back(32'hB2);
    cyc();
    chk("fl_occ2", 32'(a_occ), 2);
    put_a(32'hC2);
    a_fl = 1'b1;
    qa.delete();
    cyc();
    a_fl = 1'b0;
    a_iv = 1'b0;
    chk("fl_ov", 32'(a_ov), 0);
    chk("fl_ctrl", 32'(a_oc), 32'(BUB));
    chk("fl_data", a_od, 0);
    chk("fl_occ", 32'(a_occ), 0);
    chk("fl_ir", 32'(a_ir), 1);
    cyc();
    chk("fl_no_c", 32'(a_ov), 0);
    chk("fl_stall", 32'(a_st), 5);

    // async reset mid-operation
    put_a(32'hA3);
    qa.push_back(32'hA3);
    cyc();
    put_a(32'hB3);
    qa.push_back(32'hB3);
    cyc();
    a_iv = 1'b0;
    chk("ar_occ2", 32'(a_occ), 2);
    #2;
    rst_n = 1'b0;
    #1;
    qa.delete();
    chk("ar_ov", 32'(a_ov), 0);
    chk("ar_occ", 32'(a_occ), 0);
    chk("ar_stall", 32'(a_st), 0);
    chk("ar_ctrl", 32'(a_oc), 32'(BUB));
    chk("ar_data", a_od, 0);
    chk("ar_ir", 32'(a_ir), 1);
    @(negedge clk);
    rst_n = 1'b1;
    a_or = 1'b1;
    put_a(32'h77);
    qa.push_back(32'h77);
    cyc();
    a_iv = 1'b0;
    chk("ar_first", a_od, 32'h77);
    chk("ar_first_v", 32'(a_ov), 1);
    cyc();

    // SKID=0 pass-through
    bocc = 1'b0;
    bstall = 0;
    k = 32'h100;
    for (int i = 0; i < 12; i++) begin
      b_or = pat[i];
      b_iv = 1'b1;
      b_id = k;
      b_ic = cf(k);
      #1;
      er = !bocc || pat[i];
      chk("b_ir", 32'(b_ir), 32'(er));
      if (!er) begin
        b_or = 1'b1;
        #1;
        chk("b_ir_comb", 32'(b_ir), 1);
        b_or = 1'b0;
        #1;
      end
      if (bocc && !pat[i]) bstall++;
      if (er) begin
        qb.push_back(k);
        k = k + 1;
        bocc = 1'b1;
      end
      cyc();
      chk("b_occ", 32'(b_occ), 32'(bocc));
    end
    b_iv = 1'b0;
    b_or = 1'b1;
    repeat (3) cyc();
    chk("b_stall", 32'(b_st), 32'(bstall));
    chk("b_empty", 32'(b_occ), 0);

    // saturation
    a_or = 1'b0;
    put_a(32'h5A7);
    qa.push_back(32'h5A7);
    cyc();
    a_iv = 1'b0;
    repeat (65540) @(posedge clk);
    #1;
    chk("sat", 32'(a_st), 32'hFFFF);
    cyc();
    chk("sat_hold", 32'(a_st), 32'hFFFF);
    a_or = 1'b1;
    cyc();

    for (int i = 0; i < 20; i++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      cyc();
    end
    chk("qa_drained", 32'(qa.size()), 0);
    chk("qb_drained", 32'(qb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, handshaked pipeline stage register that generalises the fixed ID/EX, EX/MEM and MEM/WB latches into one reusable block. It carries an arbitrary control word and data payload between two pipeline stages using valid/ready flow control. It supports an optional 2-entry skid buffer that cuts the combinational ready path, and a flush that inserts a configurable bubble. A saturating stall counter is included for performance analysis.

## Interface
Parameters:
- DATA_W, 96: payload width (operands, immediate, PC).
- CTRL_W, 24: control-word width (ALU op, mem types, wb/branch/jump flags, rd).
- BUBBLE_CTRL, {CTRL_W{1'b0}}: control value presented when no valid entry (e.g. load type 3'b111, store type 2'b11).
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CLEAR_DATA, 0: 1 = payload zeroed on flush/reset-empty; 0 = payload left stale (power saving).

Ports:
- clk  in  1  stage clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  kill all held entries (mispredict / load-use bubble).
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  block can accept a beat.
- in_ctrl  in  CTRL_W  upstream control word.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  held beat valid.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  control of head entry; BUBBLE_CTRL when out_valid=0.
- out_data  out  DATA_W  payload of head entry.
- occupancy  out  2  entries held (0..2; max 1 when SKID=0).
- stall_cnt  out  16  cycles with out_valid=1 and out_ready=0; saturates at 16'hFFFF.

## Operation
- Accept: in_fire = in_valid & in_ready. Release: out_fire = out_valid & out_ready.
- SKID=1, two slots, head (main) and skid:
  - in_ready = ~skid_valid, registered with no combinational path from out_ready.
  - On in_fire, the beat goes to main if main is empty or out_fire in the same cycle. Otherwise it goes to skid.
  - On out_fire with skid valid, skid moves to main. A simultaneous in_fire then lands in skid.
  - Order is strictly FIFO. No beat is ever dropped or duplicated outside flush.
- SKID=0, one slot: in_ready = ~out_valid | out_ready (combinational). On in_fire the slot loads and is overwritten in the same edge as out_fire.
- Flush has priority over accept and release:
  - At the edge where flush=1, all slots go invalid and out_ctrl goes to BUBBLE_CTRL.
  - out_data is zeroed if CLEAR_DATA=1.
  - A beat handshaked in the flush cycle is discarded.
  - The downstream handshake in the flush cycle still completes, carrying the pre-flush head.
- out_ctrl is forced to BUBBLE_CTRL whenever the head slot is invalid, so that downstream stages never see stale write-enables.
- stall_cnt increments on every cycle with out_valid & ~out_ready, holds otherwise, saturates, and clears only on reset. Flush does not clear it.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is on out_* after edge N.
- Throughput is 1 beat/cycle sustained in both SKID modes while out_ready=1.
- SKID=1: after downstream deasserts out_ready, in_ready falls one cycle later. It rises one cycle after skid drains.
- Reset (rst_n low, asynchronous, any cycle including mid-transfer):
  - out_valid=0, out_ctrl=BUBBLE_CTRL, out_data=0, occupancy=0, stall_cnt=0.
  - in_ready=1 (SKID=1) or 1 via the combinational term (SKID=0).
- Release of rst_n is synchronous to clk. The first accept can occur at the first rising edge after release.
- After a flush edge: occupancy=0, out_valid=0, and in_ready=1 on the following cycle.

## Structure
- Shared pipeline package holds:
  - the bubble encodings LOAD_NONE=3'b111 and STORE_NONE=2'b11;
  - the per-stage control-word field offsets, so each stage instance builds BUBBLE_CTRL from named constants.
- Sub-module pipe_slot is a single valid+ctrl+data register with load, clear and bubble-on-invalid output. It is instantiated twice (main, skid), or once when SKID=0.
- Slot-steering and in_ready logic live in pipe_stage_reg.

## Test plan
- Streaming: SKID=1, out_ready=1, 8 beats in_data=1..8 back-to-back -> out_data 1..8 one cycle later each, occupancy never exceeds 1, stall_cnt=0.
- Backpressure: out_ready=0 for 3 cycles while in_valid=1 with beats A,B,C -> A held on out, B in skid, in_ready=0 from the third cycle, C held upstream; then out_ready=1 -> A,B,C in order, stall_cnt=3.
- Flush priority: occupancy=2 (A head, B skid), flush=1 with in_valid=1 carrying C, out_ready=0 -> next cycle out_valid=0, out_ctrl=BUBBLE_CTRL (load type 3'b111), occupancy=0, C discarded, in_ready=1.
- Reset mid-operation: assert rst_n=0 between edges with occupancy=2 -> outputs immediately take reset values, without waiting for a clock edge; release, first beat accepted at the next edge.
- SKID=0 pass-through: out_ready toggling 1,0,1 with continuous input -> in_ready mirrors ~out_valid|out_ready combinationally, no beat lost, occupancy ≤1.
- Saturation: hold out_valid=1, out_ready=0 for 65 540 cycles -> stall_cnt stops at 16'hFFFF.
